// File: rtl/sprite_overlay_fader.sv
// Scaled palette sprite drawn at a frame-latched origin and alpha-blended over the
// background stream; alpha fades in, holds and fades out on frame ticks. Latency 3.
module sprite_overlay_fader #(
    parameter int IMG_W       = 80,
    parameter int IMG_H       = 45,
    parameter int IDX_W       = 2,
    parameter int SCALE_SHIFT = 3,
    parameter int TRANSP_EN   = 1,
    parameter int TRANSP_IDX  = 0,
    parameter int FADE_STEP   = 2,
    parameter int HOLD_FRAMES = 120,
    parameter int ADDR_W      = $clog2(IMG_W * IMG_H)
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_tick,
    input  logic [9:0]        x0,
    input  logic [9:0]        y0,
    input  logic              show,
    input  logic              hide,
    input  logic [3:0]        bg_red,
    input  logic [3:0]        bg_green,
    input  logic [3:0]        bg_blue,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic [4:0]        alpha,
    output logic              busy,
    output logic [1:0]        fsm_state
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FADE_IN  = 2'd1;
    localparam logic [1:0] S_HOLD     = 2'd2;
    localparam logic [1:0] S_FADE_OUT = 2'd3;

    localparam logic [1:0] REQ_NONE = 2'd0;
    localparam logic [1:0] REQ_SHOW = 2'd1;
    localparam logic [1:0] REQ_HIDE = 2'd2;

    localparam int STEP_W = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [31:0] BOX_W = 32'(IMG_W) << SCALE_SHIFT;
    localparam logic [31:0] BOX_H = 32'(IMG_H) << SCALE_SHIFT;
    localparam logic [IDX_W-1:0] TRANSP_Q = IDX_W'(TRANSP_IDX);

    logic [1:0]        state;
    logic [1:0]        pending;
    logic [1:0]        req_eff;
    logic [STEP_W-1:0] step_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [9:0]        x0l, y0l;
    logic [9:0]        lx, ly;
    logic              in_box_c;
    logic [11:0]       bg1, bg2;
    logic              blank1, blank2, in_box1, in_box2;
    logic              show_bg;

    assign lx = DrawX - x0l;
    assign ly = DrawY - y0l;
    // Widened compares so the scaled sprite limits can exceed the 10-bit range.
    assign in_box_c = (DrawX >= x0l) && (DrawY >= y0l) &&
                      ({22'd0, lx} < BOX_W) && ({22'd0, ly} < BOX_H);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            bg1      <= '0;
            bg2      <= '0;
            blank1   <= 1'b0;
            blank2   <= 1'b0;
            in_box1  <= 1'b0;
            in_box2  <= 1'b0;
        end else begin
            rom_addr <= in_box_c ? (ADDR_W'(lx >> SCALE_SHIFT) +
                                    ADDR_W'(ly >> SCALE_SHIFT) * ADDR_W'(IMG_W)) : '0;
            bg1      <= {bg_red, bg_green, bg_blue};
            blank1   <= blank;
            in_box1  <= in_box_c;
            bg2      <= bg1;
            blank2   <= blank1;
            in_box2  <= in_box1;
        end
    end

    assign pal_index = rom_q;
    assign show_bg = !in_box2 || (alpha == 5'd0) || ((TRANSP_EN != 0) && (rom_q == TRANSP_Q));

    function automatic logic [3:0] mix(input logic [3:0] p, input logic [3:0] b, input logic [4:0] a);
        logic [8:0] s;
        s = {5'd0, p} * {4'd0, a} + {5'd0, b} * (9'd16 - {4'd0, a});
        return 4'(s >> 4);
    endfunction

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (!blank2) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (show_bg) begin
            red   <= bg2[11:8];
            green <= bg2[7:4];
            blue  <= bg2[3:0];
        end else begin
            red   <= mix(pal_red,   bg2[11:8], alpha);
            green <= mix(pal_green, bg2[7:4],  alpha);
            blue  <= mix(pal_blue,  bg2[3:0],  alpha);
        end
    end

    // A request arriving on the tick cycle itself is acted on at that tick; hide beats show.
    assign req_eff = hide ? REQ_HIDE : (show ? REQ_SHOW : pending);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            pending  <= REQ_NONE;
            alpha    <= '0;
            step_cnt <= '0;
            hold_cnt <= '0;
            x0l      <= '0;
            y0l      <= '0;
        end else if (!frame_tick) begin
            pending <= req_eff;
        end else begin
            pending <= REQ_NONE;
            x0l     <= x0;
            y0l     <= y0;
            case (state)
                S_IDLE: begin
                    if (req_eff == REQ_SHOW) begin
                        state    <= S_FADE_IN;
                        step_cnt <= '0;
                    end
                end
                S_FADE_IN: begin
                    if (req_eff == REQ_HIDE) begin
                        state    <= S_FADE_OUT;
                        step_cnt <= '0;
                    end else if (alpha >= 5'd16) begin
                        state    <= S_HOLD;
                        hold_cnt <= '0;
                        step_cnt <= '0;
                    end else if (step_cnt == STEP_LAST) begin
                        step_cnt <= '0;
                        alpha    <= alpha + 5'd1;
                        if (alpha == 5'd15) begin
                            state    <= S_HOLD;
                            hold_cnt <= '0;
                        end
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (req_eff == REQ_HIDE) begin
                        state    <= S_FADE_OUT;
                        step_cnt <= '0;
                    end else if (req_eff == REQ_SHOW) begin
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if ((HOLD_FRAMES != 0) && (hold_cnt == HOLD_LAST)) begin
                            state    <= S_FADE_OUT;
                            step_cnt <= '0;
                        end
                    end
                end
                default: begin
                    if (req_eff == REQ_SHOW) begin
                        state    <= S_FADE_IN;
                        step_cnt <= '0;
                    end else if (alpha == 5'd0) begin
                        state    <= S_IDLE;
                        step_cnt <= '0;
                    end else if (step_cnt == STEP_LAST) begin
                        step_cnt <= '0;
                        alpha    <= alpha - 5'd1;
                        if (alpha == 5'd1) state <= S_IDLE;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_sprite_overlay_fader.sv
// Bench for sprite_overlay_fader: frame-level fade model plus a pixel queue that
// predicts each output three cycles after its input, checked every cycle.
module tb_sprite_overlay_fader;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        blank = 1'b0, frame_tick = 1'b0;
  logic [9:0]  x0 = '0, y0 = '0;
  logic        show = 1'b0, hide = 1'b0;
  logic [3:0]  bg_red = '0, bg_green = '0, bg_blue = '0;
  logic [11:0] rom_addr;
  logic [1:0]  rom_q = '0;
  logic [1:0]  pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic [3:0]  red, green, blue;
  logic [4:0]  alpha;
  logic        busy;
  logic [1:0]  fsm_state;

  sprite_overlay_fader dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_tick(frame_tick), .x0(x0), .y0(y0),
    .show(show), .hide(hide), .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .alpha(alpha), .busy(busy),
    .fsm_state(fsm_state)
  );

  // clock / ROM / palette
  always #5 vga_clk = ~vga_clk;

  logic [1:0] rom_mem [4096];
  initial for (int a = 0; a < 4096; a++) rom_mem[a] = 2'((a % 4) ^ 1);
  always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];

  function automatic int pal_of(input int idx, input int ch);
    case (idx)
      1: return (ch == 0) ? 15 : 0;
      2: return (ch == 1) ? 15 : 0;
      3: return (ch == 0) ? 8 : ((ch == 1) ? 4 : 12);
      default: return 0;
    endcase
  endfunction

  assign pal_red   = 4'(pal_of(int'(pal_index), 0));
  assign pal_green = 4'(pal_of(int'(pal_index), 1));
  assign pal_blue  = 4'(pal_of(int'(pal_index), 2));

  // scoreboard counters
  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  typedef struct {
    bit blank; bit inbox; int addr; int bg_r; int bg_g; int bg_b;
  } px_t;

  localparam int P_IDLE = 0, P_IN = 1, P_HOLD = 2, P_OUT = 3;
  localparam int R_NONE = 0, R_SHOW = 1, R_HIDE = 2;

  px_t px_q[$];
  px_t op, np;
  int m_alpha = 0, m_phase = P_IDLE, m_t = 0, m_req = R_NONE, m_x0 = 0, m_y0 = 0;
  int exp_r = 0, exp_g = 0, exp_b = 0, exp_addr = 0;
  int lx, ly, req_now;

  function automatic int blend(input px_t p, input int ch, input int a);
    int idx, pv, bv;
    idx = int'(rom_mem[p.addr]);
    pv = pal_of(idx, ch);
    bv = (ch == 0) ? p.bg_r : ((ch == 1) ? p.bg_g : p.bg_b);
    if (!p.blank) return 0;
    if (!p.inbox || a == 0 || idx == 0) return bv;
    return (pv * a + bv * (16 - a)) / 16;
  endfunction

  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      px_q.delete();
      np = '{default: 0};
      px_q.push_back(np);
      px_q.push_back(np);
      m_alpha = 0; m_phase = P_IDLE; m_t = 0; m_req = R_NONE; m_x0 = 0; m_y0 = 0;
      exp_r = 0; exp_g = 0; exp_b = 0; exp_addr = 0;
    end else begin
      op = px_q.pop_front();
      exp_r = blend(op, 0, m_alpha);
      exp_g = blend(op, 1, m_alpha);
      exp_b = blend(op, 2, m_alpha);
      lx = (int'(DrawX) - m_x0) & 1023;
      ly = (int'(DrawY) - m_y0) & 1023;
      np.blank = blank;
      np.inbox = (int'(DrawX) >= m_x0) && (int'(DrawY) >= m_y0) && (lx < 80 * 8) && (ly < 45 * 8);
      np.addr = np.inbox ? (lx / 8) + (ly / 8) * 80 : 0;
      np.bg_r = int'(bg_red); np.bg_g = int'(bg_green); np.bg_b = int'(bg_blue);
      px_q.push_back(np);
      exp_addr = np.addr;
      req_now = hide ? R_HIDE : (show ? R_SHOW : m_req);
      if (!frame_tick) begin
        m_req = req_now;
      end else begin
        m_req = R_NONE;
        m_x0 = int'(x0); m_y0 = int'(y0);
        case (m_phase)
          P_IDLE: if (req_now == R_SHOW) begin m_phase = P_IN; m_t = 0; end
          P_IN: begin
            if (req_now == R_HIDE) begin m_phase = P_OUT; m_t = 0; end
            else begin
              m_t++;
              if (m_t % 2 == 0 && m_alpha < 16) m_alpha++;
              if (m_alpha == 16) begin m_phase = P_HOLD; m_t = 0; end
            end
          end
          P_HOLD: begin
            if (req_now == R_HIDE) begin m_phase = P_OUT; m_t = 0; end
            else if (req_now == R_SHOW) m_t = 0;
            else begin
              m_t++;
              if (m_t == 120) begin m_phase = P_OUT; m_t = 0; end
            end
          end
          default: begin
            if (req_now == R_SHOW) begin m_phase = P_IN; m_t = 0; end
            else begin
              m_t++;
              if (m_t % 2 == 0 && m_alpha > 0) m_alpha--;
              if (m_alpha == 0) begin m_phase = P_IDLE; m_t = 0; end
            end
          end
        endcase
      end
    end
  end

  // compare process
  always @(negedge vga_clk) begin
    if (chk_en) begin
      chk("red", int'(red), exp_r);
      chk("green", int'(green), exp_g);
      chk("blue", int'(blue), exp_b);
      chk("rom_addr", int'(rom_addr), exp_addr);
      chk("alpha", int'(alpha), m_alpha);
      chk("busy", int'(busy), (m_phase != P_IDLE) ? 1 : 0);
      chk("pal_index", int'(pal_index), int'(rom_q));
    end
  end

  // driver tasks (called at a negedge)
  task automatic px(input int x, input int y, input bit bl);
    DrawX = 10'(x); DrawY = 10'(y); blank = bl;
    @(negedge vga_clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge vga_clk);
    frame_tick = 1'b0;
  endtask

  task automatic pulse(input bit s, input bit h);
    show = s; hide = h;
    @(negedge vga_clk);
    show = 1'b0; hide = 1'b0;
  endtask

  task automatic set_bg(input int r, input int g, input int b);
    bg_red = 4'(r); bg_green = 4'(g); bg_blue = 4'(b);
  endtask

  task automatic chk_rgb(input string name, input int r, input int g, input int b);
    chk({name, "_r"}, int'(red), r);
    chk({name, "_g"}, int'(green), g);
    chk({name, "_b"}, int'(blue), b);
  endtask

  initial begin
    repeat (3) @(negedge vga_clk);
    chk("reset_addr", int'(rom_addr), 0);
    chk("reset_alpha", int'(alpha), 0);
    chk("reset_busy", int'(busy), 0);
    chk_rgb("reset_rgb", 0, 0, 0);
    chk_en = 1;
    reset_n = 1'b1;
    set_bg(2, 4, 6);
    @(negedge vga_clk);

    // fade in, hold, fade out
    pulse(1, 0);
    tick();
    chk("fi_entry_alpha", int'(alpha), 0);
    chk("fi_entry_busy", int'(busy), 1);
    tick(); chk("fi_t1", int'(alpha), 0);
    tick(); chk("fi_t2", int'(alpha), 1);
    tick(); chk("fi_t3", int'(alpha), 1);
    tick(); chk("fi_t4", int'(alpha), 2);
    repeat (28) tick();
    chk("fi_full", int'(alpha), 16);
    chk("hold_busy", int'(busy), 1);
    repeat (119) tick();
    chk("hold_119", int'(alpha), 16);
    tick(); tick(); tick();
    chk("fo_t2", int'(alpha), 15);
    repeat (29) tick();
    chk("fo_t31", int'(alpha), 1);
    chk("fo_t31_busy", int'(busy), 1);
    tick();
    chk("fo_done", int'(alpha), 0);
    chk("fo_done_busy", int'(busy), 0);

    // static frame at (100,50), alpha 16
    x0 = 10'd100; y0 = 10'd50;
    pulse(1, 0);
    repeat (33) tick();
    chk("t2_alpha", int'(alpha), 16);
    repeat (4) px(99, 50, 1);
    px(100, 50, 1);
    px(99, 50, 1);
    chk_rgb("pre_latency", 2, 4, 6);
    px(99, 50, 1);
    chk_rgb("origin_px", 15, 0, 0);
    px(99, 50, 1);
    chk_rgb("left_of_box", 2, 4, 6);
    px(739, 50, 1); px(740, 50, 1); px(740, 50, 1);
    chk_rgb("right_edge_in", 0, 15, 0);
    px(740, 50, 1);
    chk_rgb("right_edge_out", 2, 4, 6);

    // scaling at origin (0,0)
    x0 = '0; y0 = '0;
    tick();
    px(15, 9, 1);
    chk("addr_15_9", int'(rom_addr), 81);
    px(639, 359, 1);
    chk("addr_last", int'(rom_addr), 3599);
    px(0, 360, 1);
    chk("addr_below", int'(rom_addr), 0);
    px(0, 360, 1); px(0, 360, 1);
    chk_rgb("below_bg", 2, 4, 6);

    // blend at alpha 8
    set_bg(1, 3, 5);
    pulse(0, 1);
    tick();
    repeat (16) tick();
    chk("a8", int'(alpha), 8);
    px(0, 0, 1); px(0, 0, 1); px(0, 0, 1);
    chk_rgb("blend8", 8, 1, 2);
    px(8, 0, 1); px(8, 0, 1); px(8, 0, 1);
    chk_rgb("transparent", 1, 3, 5);
    px(0, 0, 0); px(0, 0, 0); px(0, 0, 0);
    chk_rgb("blanked", 0, 0, 0);
    px(0, 0, 1);

    // request races
    repeat (6) tick();
    chk("fo_a5", int'(alpha), 5);
    pulse(1, 0);
    tick(); chk("refade_entry", int'(alpha), 5);
    tick(); chk("refade_t1", int'(alpha), 5);
    tick(); chk("refade_t2", int'(alpha), 6);
    repeat (20) tick();
    chk("refade_full", int'(alpha), 16);
    pulse(1, 1);
    tick(); chk("race_entry", int'(alpha), 16);
    tick(); tick();
    chk("race_hide_wins", int'(alpha), 15);
    repeat (30) tick();
    chk("race_idle", int'(busy), 0);
    pulse(0, 1);
    repeat (5) tick();
    chk("idle_hide", int'(busy), 0);
    pulse(1, 0);
    pulse(0, 1);
    tick();
    chk("latest_wins", int'(busy), 0);
    show = 1'b1; frame_tick = 1'b1;
    @(negedge vga_clk);
    show = 1'b0; frame_tick = 1'b0;
    chk("same_cycle_show", int'(busy), 1);

    // async reset mid fade-in
    repeat (18) tick();
    chk("a9", int'(alpha), 9);
    chk_rgb("a9_rgb", 8, 1, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_alpha", int'(alpha), 0);
    chk("async_busy", int'(busy), 0);
    chk_rgb("async_rgb", 0, 0, 0);
    @(negedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
    x0 = 10'd200;
    px(16, 8, 1);
    chk("origin_held", int'(rom_addr), 82);
    tick();
    px(216, 8, 1);
    chk("origin_new", int'(rom_addr), 82);
    px(16, 8, 1);
    chk("origin_old_out", int'(rom_addr), 0);
    repeat (4) px(16, 8, 1);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
